// File: rtl/alu_op_sequencer.sv
// Control FSM in front of the calculator ALU: one request per handshake, owns ACC and FLAGS.
// Optional multi-cycle factorial sequencing is compiled in with `define SEQ_FACT_EN.
module alu_op_sequencer #(
  parameter int         WIDTH   = 16,
  parameter int         ALU_LAT = 1,
  parameter logic [5:0] OP_LDI  = 6'b000001,
  parameter logic [5:0] OP_MUL  = 6'b001001,
  parameter logic [5:0] OP_FACT = 6'b001111
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             REQ_VALID,
  output logic             REQ_READY,
  input  logic [5:0]       REQ_OPCODE,
  input  logic             REQ_REG_ADDR,
  input  logic [WIDTH-1:0] REQ_IMM,
  output logic             ALU_EN,
  output logic [5:0]       ALU_OPCODE,
  output logic             ALU_REG_ADDR,
  output logic [WIDTH-1:0] ALU_IMM,
  input  logic [WIDTH-1:0] ALU_RES,
  input  logic [3:0]       ALU_FLAGS,
  output logic [WIDTH-1:0] ACC,
  output logic [3:0]       FLAGS,
  output logic             DONE,
  output logic             BUSY
);

  localparam int WCW = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT,
`ifdef SEQ_FACT_EN
    FACT_CHK,
`endif
    WB
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [3:0]       flags_q, flags_d;
  logic             alu_en_q, alu_en_d;
  logic [5:0]       alu_opcode_q, alu_opcode_d;
  logic             alu_reg_addr_q, alu_reg_addr_d;
  logic [WIDTH-1:0] alu_imm_q, alu_imm_d;
  logic             done_q, done_d;
  logic             ready_q, ready_d;
  logic [WCW-1:0]   wait_cnt_q, wait_cnt_d;
`ifdef SEQ_FACT_EN
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             fact_q, fact_d;
`endif

  always_comb begin
    state_d        = state_q;
    acc_d          = acc_q;
    flags_d        = flags_q;
    alu_en_d       = alu_en_q;
    alu_opcode_d   = alu_opcode_q;
    alu_reg_addr_d = alu_reg_addr_q;
    alu_imm_d      = alu_imm_q;
    done_d         = 1'b0;
    ready_d        = ready_q;
    wait_cnt_d     = wait_cnt_q;
`ifdef SEQ_FACT_EN
    cnt_d          = cnt_q;
    fact_d         = fact_q;
`endif
    case (state_q)
      IDLE: begin
        ready_d = 1'b1;
        if (REQ_VALID) begin
          alu_opcode_d   = REQ_OPCODE;
          alu_reg_addr_d = REQ_REG_ADDR;
          alu_imm_d      = REQ_IMM;
          ready_d        = 1'b0;
          if (REQ_OPCODE == OP_LDI) begin
            acc_d   = REQ_IMM;
            done_d  = 1'b1;
            state_d = WB;
          end
`ifdef SEQ_FACT_EN
          else if (REQ_OPCODE == OP_FACT) begin
            // ACC starts at 1 and is multiplied down by N, N-1, ... 2
            acc_d        = WIDTH'(1);
            flags_d      = 4'h0;
            cnt_d        = REQ_IMM;
            fact_d       = 1'b1;
            alu_opcode_d = OP_MUL;
            state_d      = FACT_CHK;
          end
`endif
          else begin
            alu_en_d = 1'b1;
            state_d  = ISSUE;
`ifdef SEQ_FACT_EN
            fact_d   = 1'b0;
`endif
          end
        end
      end
      ISSUE: begin
        wait_cnt_d = WCW'(ALU_LAT - 1);
        state_d    = WAIT;
      end
      WAIT: begin
        if (wait_cnt_q == '0) begin
          acc_d    = ALU_RES;
          alu_en_d = 1'b0;
`ifdef SEQ_FACT_EN
          if (fact_q) begin
            // overflow is sticky across the whole product chain
            flags_d = {ALU_FLAGS[3:1], flags_q[0] | ALU_FLAGS[0]};
            cnt_d   = cnt_q - WIDTH'(1);
            state_d = FACT_CHK;
          end else begin
            flags_d = ALU_FLAGS;
            done_d  = 1'b1;
            state_d = WB;
          end
`else
          flags_d = ALU_FLAGS;
          done_d  = 1'b1;
          state_d = WB;
`endif
        end else begin
          wait_cnt_d = wait_cnt_q - WCW'(1);
        end
      end
`ifdef SEQ_FACT_EN
      FACT_CHK: begin
        if (cnt_q <= WIDTH'(1)) begin
          done_d  = 1'b1;
          state_d = WB;
        end else begin
          alu_imm_d = cnt_q;
          alu_en_d  = 1'b1;
          state_d   = ISSUE;
        end
      end
`endif
      WB: begin
        ready_d = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q        <= IDLE;
      acc_q          <= '0;
      flags_q        <= '0;
      alu_en_q       <= 1'b0;
      alu_opcode_q   <= '0;
      alu_reg_addr_q <= 1'b0;
      alu_imm_q      <= '0;
      done_q         <= 1'b0;
      ready_q        <= 1'b1;
      wait_cnt_q     <= '0;
`ifdef SEQ_FACT_EN
      cnt_q          <= '0;
      fact_q         <= 1'b0;
`endif
    end else begin
      state_q        <= state_d;
      acc_q          <= acc_d;
      flags_q        <= flags_d;
      alu_en_q       <= alu_en_d;
      alu_opcode_q   <= alu_opcode_d;
      alu_reg_addr_q <= alu_reg_addr_d;
      alu_imm_q      <= alu_imm_d;
      done_q         <= done_d;
      ready_q        <= ready_d;
      wait_cnt_q     <= wait_cnt_d;
`ifdef SEQ_FACT_EN
      cnt_q          <= cnt_d;
      fact_q         <= fact_d;
`endif
    end
  end

  assign REQ_READY    = ready_q;
  assign BUSY         = ~ready_q;
  assign ALU_EN       = alu_en_q;
  assign ALU_OPCODE   = alu_opcode_q;
  assign ALU_REG_ADDR = alu_reg_addr_q;
  assign ALU_IMM      = alu_imm_q;
  assign ACC          = acc_q;
  assign FLAGS        = flags_q;
  assign DONE         = done_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Scoreboard bench for alu_op_sequencer with a behavioural ALU and X/Y operand registers.
module tb_alu_op_sequencer;

  localparam logic [5:0] OP_LDI  = 6'b000001;
  localparam logic [5:0] OP_ADD  = 6'b000111;
  localparam logic [5:0] OP_SUB  = 6'b001000;
  localparam logic [5:0] OP_MUL  = 6'b001001;
  localparam logic [5:0] OP_FACT = 6'b001111;

  logic        CLK = 1'b0;
  logic        RST;
  logic        REQ_VALID;
  logic        REQ_READY;
  logic [5:0]  REQ_OPCODE;
  logic        REQ_REG_ADDR;
  logic [15:0] REQ_IMM;
  logic        ALU_EN;
  logic [5:0]  ALU_OPCODE;
  logic        ALU_REG_ADDR;
  logic [15:0] ALU_IMM;
  logic [15:0] ALU_RES;
  logic [3:0]  ALU_FLAGS;
  logic [15:0] ACC;
  logic [3:0]  FLAGS;
  logic        DONE;
  logic        BUSY;

  logic [15:0] x_reg = 16'h0003;
  logic [15:0] y_reg = 16'h0000;

  int          n_checks = 0;
  int          n_err    = 0;
  int          busy_cnt = 0;
  int          en_cnt   = 0;
  int          done_cnt = 0;
  logic        en_prev  = 1'b0;
  logic [19:0] exp_q[$];
  logic [15:0] imm_log[$];
  logic [15:0] m_acc   = '0;
  logic [3:0]  m_flags = '0;

  alu_op_sequencer dut (
    .CLK(CLK), .RST(RST),
    .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY), .REQ_OPCODE(REQ_OPCODE),
    .REQ_REG_ADDR(REQ_REG_ADDR), .REQ_IMM(REQ_IMM),
    .ALU_EN(ALU_EN), .ALU_OPCODE(ALU_OPCODE), .ALU_REG_ADDR(ALU_REG_ADDR),
    .ALU_IMM(ALU_IMM), .ALU_RES(ALU_RES), .ALU_FLAGS(ALU_FLAGS),
    .ACC(ACC), .FLAGS(FLAGS), .DONE(DONE), .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  // Behavioural ALU: returns {zero, neg, carry, ovf, result}
  function automatic logic [19:0] alu_f(input logic [5:0] op, input logic addr,
                                        input logic [15:0] imm, input logic [15:0] a);
    logic [15:0] b, r;
    logic [16:0] s;
    logic [31:0] p;
    logic        ovf, c;
    b = (addr ? y_reg : x_reg) + imm;
    r = a; ovf = 1'b0; c = 1'b0;
    case (op)
      OP_ADD: begin
        s = {1'b0, a} + {1'b0, b}; r = s[15:0]; c = s[16];
        ovf = (a[15] == b[15]) && (r[15] != a[15]);
      end
      OP_SUB: begin
        s = {1'b0, a} - {1'b0, b}; r = s[15:0]; c = s[16];
        ovf = (a[15] != b[15]) && (r[15] != a[15]);
      end
      OP_MUL: begin
        p = {16'h0, a} * {16'h0, imm}; r = p[15:0];
        ovf = |p[31:16];
      end
      default: ;
    endcase
    return {(r == 16'h0), r[15], c, ovf, r};
  endfunction

  always_comb begin
    if (ALU_EN) {ALU_FLAGS, ALU_RES} = alu_f(ALU_OPCODE, ALU_REG_ADDR, ALU_IMM, ACC);
    else        {ALU_FLAGS, ALU_RES} = {4'h0, 16'hDEAD};
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference for the sequencer's architectural effect of one request
  function automatic logic [19:0] model(input logic [5:0] op, input logic addr,
                                        input logic [15:0] imm);
    logic [19:0] t;
    if (op == OP_LDI) begin
      m_acc = imm;
    end
`ifdef SEQ_FACT_EN
    else if (op == OP_FACT) begin
      m_acc = 16'h1; m_flags = 4'h0;
      for (int k = int'(imm); k > 1; k--) begin
        t = alu_f(OP_MUL, 1'b0, 16'(k), m_acc);
        m_acc = t[15:0];
        m_flags = {t[19:17], m_flags[0] | t[16]};
      end
    end
`endif
    else begin
      t = alu_f(op, addr, imm, m_acc);
      m_acc = t[15:0]; m_flags = t[19:16];
    end
    return {m_flags, m_acc};
  endfunction

  always @(negedge CLK) begin
    logic [19:0] e;
    if (RST) begin
      if (!REQ_READY) busy_cnt++;
      if (ALU_EN) en_cnt++;
      if (ALU_EN && !en_prev) imm_log.push_back(ALU_IMM);
      en_prev = ALU_EN;
      check("busy_vs_ready", BUSY, !REQ_READY);
      if (DONE) begin
        done_cnt++;
        if (exp_q.size() == 0) begin
          check("done_unexpected", DONE, 1'b0);
        end else begin
          e = exp_q.pop_front();
          check("acc", ACC, e[15:0]);
          check("flags", FLAGS, e[19:16]);
        end
      end
    end else begin
      en_prev = 1'b0;
    end
  end

  task automatic send(input logic [5:0] op, input logic addr, input logic [15:0] imm,
                      input bit keep);
    int n;
    REQ_VALID = 1'b1; REQ_OPCODE = op; REQ_REG_ADDR = addr; REQ_IMM = imm;
    n = 0;
    while (!REQ_READY && n < 50) begin
      @(negedge CLK); #1; n++;
    end
    check("accept_ready", REQ_READY, 1'b1);
    exp_q.push_back(model(op, addr, imm));
    busy_cnt = 0; en_cnt = 0;
    @(negedge CLK); #1;
    if (!keep) REQ_VALID = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    do begin
      @(negedge CLK); #1; n++;
    end while ((!REQ_READY || exp_q.size() != 0) && n < 60);
    check("pending_results", exp_q.size(), 0);
  endtask

  initial begin
    int d0;
    RST = 1'b0; REQ_VALID = 1'b0; REQ_OPCODE = '0; REQ_REG_ADDR = 1'b0; REQ_IMM = '0;
    repeat (3) @(negedge CLK);
    #1;
    check("rst_acc", ACC, 16'h0);
    check("rst_flags", FLAGS, 4'h0);
    check("rst_ready", REQ_READY, 1'b1);
    check("rst_alu_en", ALU_EN, 1'b0);
    check("rst_done", DONE, 1'b0);
    check("rst_alu_imm", ALU_IMM, 16'h0);
    RST = 1'b1;
    @(negedge CLK); #1;

    // LDI then ADD with Y, including READY/ALU_EN timing
    y_reg = 16'd14;
    send(OP_LDI, 1'b0, 16'd2, 1'b0);
    wait_idle();
    check("ldi_busy_cycles", busy_cnt, 1);
    send(OP_ADD, 1'b1, 16'd0, 1'b0);
    wait_idle();
    check("add_acc_16", ACC, 16'd16);
    check("add_busy_cycles", busy_cnt, 3);
    check("add_en_cycles", en_cnt, 2);

    // signed overflow into the sign bit, then subtract to zero
    y_reg = 16'd2;
    send(OP_LDI, 1'b0, 16'h7FFE, 1'b0);
    wait_idle();
    send(OP_ADD, 1'b1, 16'd0, 1'b0);
    wait_idle();
    check("ovf_acc", ACC, 16'h8000);
    check("ovf_flags", FLAGS, 4'b0101);
    y_reg = 16'h8000;
    send(OP_SUB, 1'b1, 16'd0, 1'b0);
    wait_idle();
    check("sub_zero_flags", FLAGS, 4'b1000);

    // VALID held across two requests
    y_reg = 16'd1;
    d0 = done_cnt;
    send(OP_ADD, 1'b1, 16'd0, 1'b1);
    send(OP_ADD, 1'b1, 16'd5, 1'b0);
    wait_idle();
    check("b2b_done_count", done_cnt - d0, 2);
    check("b2b_acc", ACC, 16'd7);
    check("b2b_second_busy", busy_cnt, 3);

`ifdef SEQ_FACT_EN
    d0 = done_cnt;
    imm_log.delete();
    send(OP_FACT, 1'b0, 16'd5, 1'b0);
    wait_idle();
    check("fact5_acc", ACC, 16'd120);
    check("fact5_done", done_cnt - d0, 1);
    check("fact5_mul_count", imm_log.size(), 4);
    for (int i = 0; i < 4 && i < imm_log.size(); i++)
      check("fact5_mul_imm", imm_log[i], 16'(5 - i));
    send(OP_FACT, 1'b0, 16'd0, 1'b0);
    wait_idle();
    check("fact0_acc", ACC, 16'd1);
    check("fact0_en_cycles", en_cnt, 0);
    check("fact0_busy", busy_cnt, 2);
    send(OP_FACT, 1'b0, 16'd9, 1'b0);
    wait_idle();
    check("fact9_ovf", FLAGS[0], 1'b1);
`else
    // without the sequencing option FACT is a single plain ALU cycle
    send(OP_FACT, 1'b0, 16'd5, 1'b0);
    wait_idle();
    check("fact_plain_en", en_cnt, 2);
    check("fact_plain_acc", ACC, 16'd7);
`endif

    // reset in the middle of an ADD
    y_reg = 16'd3;
    send(OP_ADD, 1'b1, 16'd0, 1'b0);
    @(negedge CLK); #1;
    RST = 1'b0;
    #1;
    check("abort_acc", ACC, 16'h0);
    check("abort_alu_en", ALU_EN, 1'b0);
    check("abort_ready", REQ_READY, 1'b1);
    check("abort_done", DONE, 1'b0);
    exp_q.delete();
    m_acc = '0; m_flags = '0;
    d0 = done_cnt;
    repeat (2) @(negedge CLK);
    #1;
    RST = 1'b1;
    @(negedge CLK); #1;
    check("abort_no_done", done_cnt - d0, 0);
    send(OP_LDI, 1'b0, 16'd7, 1'b0);
    wait_idle();
    check("after_abort_ldi", ACC, 16'd7);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule
